// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, ALU selects, sequencer states and the opcode-to-ALU control mapping
package alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [1:0] ALUSEL_AND = 2'b00;
  localparam logic [1:0] ALUSEL_OR  = 2'b01;
  localparam logic [1:0] ALUSEL_ADD = 2'b10;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;
  typedef struct packed {
    logic       binvert;
    logic       carryin;
    logic [1:0] sel;
  } alu_ctrl_t;
  function automatic logic op_legal(input logic [2:0] op);
    return op == OP_AND || op == OP_OR || op == OP_ADD || op == OP_SUB || op == OP_SLT;
  endfunction
  // SUB and SLT both use the invert-and-carry-in subtract path; illegal maps to AND
  function automatic alu_ctrl_t alu_ctrl(input logic [2:0] op);
    return (op == OP_SUB || op == OP_SLT) ? {1'b1, 1'b1, ALUSEL_ADD} :
           op == OP_ADD                  ? {1'b0, 1'b0, ALUSEL_ADD} :
           op == OP_OR                   ? {1'b0, 1'b0, ALUSEL_OR}  :
                                           {1'b0, 1'b0, ALUSEL_AND};
  endfunction
endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: turns raw ALU result/carry into the final result and status flags
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_eff,
  input  logic [WIDTH-1:0] result,
  input  logic             carryout,
  output logic [WIDTH-1:0] final_result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);
  logic legal;
  logic arith;
  logic raw_ovf;
  // SLT corrects the sign of the difference with the overflow bit to get signed a<b
  always_comb begin
    legal        = op_legal(op);
    arith        = op == OP_ADD || op == OP_SUB;
    raw_ovf      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    final_result = !legal ? '0 :
                   op == OP_SLT ? {{(WIDTH-1){1'b0}}, result[WIDTH-1] ^ raw_ovf} : result;
    zero         = legal && final_result == '0;
    neg          = final_result[WIDTH-1];
    carry        = arith && carryout;
    ovf          = arith && raw_ovf;
    err          = !legal;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: handshake front-end that drives an external combinational ALU and returns result plus flags
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_binvert,
  output logic             alu_carryin,
  output logic [1:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_err
);
  state_t           state;
  logic [2:0]       op_q;
  alu_ctrl_t        ctrl;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] fg_result;
  logic             fg_zero;
  logic             fg_neg;
  logic             fg_carry;
  logic             fg_ovf;
  logic             fg_err;

  assign alu_binvert   = ctrl.binvert;
  assign alu_carryin   = ctrl.carryin;
  assign alu_operation = ctrl.sel;
  assign b_eff         = ctrl.binvert ? ~alu_b : alu_b;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .op          (op_q),
    .a           (alu_a),
    .b_eff       (b_eff),
    .result      (alu_result),
    .carryout    (alu_carryout),
    .final_result(fg_result),
    .zero        (fg_zero),
    .neg         (fg_neg),
    .carry       (fg_carry),
    .ovf         (fg_ovf),
    .err         (fg_err)
  );

  // IDLE latches a command, EXEC captures the settled ALU output, RESP holds it until taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      op_q       <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      ctrl       <= '0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_q     <= in_op;
          alu_a    <= in_a;
          alu_b    <= in_b;
          ctrl     <= alu_ctrl(in_op);
          in_ready <= 1'b0;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          out_result <= fg_result;
          out_zero   <= fg_zero;
          out_neg    <= fg_neg;
          out_carry  <= fg_carry;
          out_ovf    <= fg_ovf;
          out_err    <= fg_err;
          out_valid  <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: random and directed commands checked cycle by cycle against a behavioural model
module tb_alu_op_sequencer;
  import alu_pkg::*;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic z, n, c, v, e;
  } resp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   in_op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready;
  logic [W-1:0] alu_a, alu_b, alu_result, out_result, bx;
  logic [W:0]   sum;
  logic         alu_binvert, alu_carryin, alu_carryout;
  logic [1:0]   alu_operation;
  logic         out_valid, out_zero, out_neg, out_carry, out_ovf, out_err;

  int vectors = 0;
  int miscompares = 0;
  int since = -1;
  logic [2:0]   m_op;
  logic [W-1:0] m_a, m_b;
  resp_t        m_exp;
  resp_t        got;
  int           lat;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_binvert(alu_binvert), .alu_carryin(alu_carryin),
    .alu_operation(alu_operation), .alu_result(alu_result), .alu_carryout(alu_carryout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry), .out_ovf(out_ovf), .out_err(out_err)
  );

  // the external 32-bit ALU the sequencer controls
  always_comb begin
    bx           = alu_binvert ? ~alu_b : alu_b;
    sum          = {1'b0, alu_a} + {1'b0, bx} + {{W{1'b0}}, alu_carryin};
    alu_result   = alu_operation == 2'b00 ? (alu_a & bx) :
                   alu_operation == 2'b01 ? (alu_a | bx) :
                   alu_operation == 2'b10 ? sum[W-1:0] : '0;
    alu_carryout = alu_operation == 2'b10 && sum[W];
  end

  function automatic resp_t ref_calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    resp_t x;
    logic [W:0] s;
    x = '0;
    case (op)
      OP_AND: x.r = a & b;
      OP_OR:  x.r = a | b;
      OP_ADD: begin
        s   = {1'b0, a} + {1'b0, b};
        x.r = s[W-1:0];
        x.c = s[W];
        x.v = (a[W-1] == b[W-1]) && (x.r[W-1] != a[W-1]);
      end
      OP_SUB: begin
        x.r = a - b;
        x.c = a >= b;
        x.v = (a[W-1] != b[W-1]) && (x.r[W-1] != a[W-1]);
      end
      OP_SLT: x.r = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      default: x.e = 1'b1;
    endcase
    x.z = !x.e && x.r == '0;
    x.n = x.r[W-1];
    return x;
  endfunction

  function automatic logic [3:0] exp_ctrl(input logic [2:0] op);
    return (op == OP_SUB || op == OP_SLT) ? 4'b1110 : op == OP_ADD ? 4'b0010 : op == OP_OR ? 4'b0001 : 4'b0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got_v, exp_v, $time);
    end
  endtask

  // model: cycles since acceptance, -1 when a new command may be taken
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) since = -1;
    else if (since < 0) begin
      if (in_valid) begin
        m_op = in_op; m_a = in_a; m_b = in_b;
        m_exp = ref_calc(in_op, in_a, in_b);
        since = 1;
      end
    end else if (since == 1) since = 2;
    else if (out_ready) since = -1;
  end

  // compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (reset_n) begin
      chk("in_ready", 64'(in_ready), 64'(since < 0));
      chk("out_valid", 64'(out_valid), 64'(since == 2));
      if (since == 1) begin
        chk("alu_ctrl", 64'({alu_binvert, alu_carryin, alu_operation}), 64'(exp_ctrl(m_op)));
        chk("alu_ab", {alu_a, alu_b}, {m_a, m_b});
      end
      if (since == 2)
        chk("resp", 64'({out_result, out_zero, out_neg, out_carry, out_ovf, out_err}), 64'(m_exp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                      input bit pre, input logic [2:0] nop, input logic [W-1:0] na, input logic [W-1:0] nb);
    int n;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin
      miscompares++;
      $display("FAIL accept_timeout: in_ready stuck 0");
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    if (!out_valid) begin
      miscompares++;
      $display("FAIL resp_timeout: out_valid stuck 0");
    end
    if (pre) begin in_op = nop; in_a = na; in_b = nb; in_valid = 1'b1; end
    repeat (hold) tick();
    got = {out_result, out_zero, out_neg, out_carry, out_ovf, out_err};
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h7fffffff;
      2: return 32'h80000000;
      3: return 32'hffffffff;
      4: return W'($urandom_range(0, 7));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outs", 64'({out_valid, out_result, out_zero, out_neg, out_carry, out_ovf, out_err}), 64'd0);
    chk("rst_alu", 64'({alu_a, alu_binvert, alu_carryin, alu_operation}), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    send(OP_AND, 32'ha5a5a5a5, 32'h1, 0, 0, 0, 0, 0);
    chk("and_res", 64'(got), 64'({32'h00000001, 5'b00000}));
    chk("and_lat", 64'(lat), 64'd1);
    send(OP_OR, 32'ha5a5a5a5, 32'h1, 0, 0, 0, 0, 0);
    chk("or_res", 64'(got), 64'({32'ha5a5a5a5, 5'b01000}));
    chk("or_lat", 64'(lat), 64'd1);
    send(OP_ADD, 32'ha5a5a5a5, 32'h1, 0, 0, 0, 0, 0);
    chk("add_res", 64'(got), 64'({32'ha5a5a5a6, 5'b01000}));
    send(OP_SUB, 32'ha5a5a5a5, 32'h1, 0, 0, 0, 0, 0);
    chk("sub_res", 64'(got), 64'({32'ha5a5a5a4, 5'b01100}));
    send(OP_ADD, 32'h7fffffff, 32'h1, 0, 0, 0, 0, 0);
    chk("add_ovf", 64'(got), 64'({32'h80000000, 5'b01010}));
    send(OP_SLT, 32'h80000000, 32'h1, 0, 0, 0, 0, 0);
    chk("slt_ovf", 64'(got), 64'({32'h00000001, 5'b00000}));
    send(OP_SLT, 32'hffffffff, 32'h1, 0, 0, 0, 0, 0);
    chk("slt_neg", 64'(got), 64'({32'h00000001, 5'b00000}));
    send(OP_SLT, 32'h5, 32'h5, 0, 0, 0, 0, 0);
    chk("slt_eq", 64'(got), 64'({32'h00000000, 5'b10000}));
    send(OP_ADD, 32'h1, 32'h2, 3, 1, OP_OR, 32'hf0, 32'h0f);
    chk("bp_res", 64'(got), 64'({32'h00000003, 5'b00000}));
    send(OP_OR, 32'hf0, 32'h0f, 0, 0, 0, 0, 0);
    chk("bp_next", 64'(got), 64'({32'h000000ff, 5'b00000}));
    send(3'b011, 32'h5, 32'h5, 0, 0, 0, 0, 0);
    chk("illegal", 64'(got), 64'({32'h00000000, 5'b00001}));

    in_op = OP_ADD; in_a = 32'h1234; in_b = 32'h4321; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_outs", 64'({out_valid, out_result, out_err}), 64'd0);
    chk("arst_alu", 64'({alu_a, alu_binvert, alu_carryin, alu_operation}), 64'd0);
    chk("arst_alu_b", 64'(alu_b), 64'd0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("arst_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) :
           ($urandom_range(0, 1) == 0) ? OP_SUB : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) op = OP_SLT;
      send(op, rnd_val(), rnd_val(), $urandom_range(0, 3), 0, 0, 0, 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
